// File: rtl/coinc_usb_pkg.sv
// Shared definitions for the FT245-style byte link: command byte codes, bus width
// and the read-strobe state machine encoding.
package coinc_usb_pkg;

    localparam int BYTE_W = 8;

    localparam logic [BYTE_W-1:0] CMD_CLEAR  = 8'd1;
    localparam logic [BYTE_W-1:0] CMD_ADRCLR = 8'd2;
    localparam logic [BYTE_W-1:0] CMD_WAVE   = 8'd3;
    localparam logic [BYTE_W-1:0] CMD_RDINIT = 8'd4;
    localparam logic [BYTE_W-1:0] CMD_XFER   = 8'd5;
    localparam logic [BYTE_W-1:0] CMD_IDLE   = 8'd6;
    localparam logic [BYTE_W-1:0] CMD_NORMAL = 8'd7;
    localparam logic [BYTE_W-1:0] CMD_LEN    = 8'd8;
    localparam logic [BYTE_W-1:0] CMD_THUP32 = 8'd16;
    localparam logic [BYTE_W-1:0] CMD_THDN32 = 8'd17;
    localparam logic [BYTE_W-1:0] CMD_THUP4  = 8'd18;
    localparam logic [BYTE_W-1:0] CMD_THDN4  = 8'd19;

    typedef enum logic [1:0] {
        RD_IDLE  = 2'd0,
        RD_DRIVE = 2'd1,
        RD_HOLD  = 2'd2
    } rd_state_e;

endpackage

// File: rtl/sync_byte_fifo.sv
// Single-clock byte FIFO with an occupancy counter; the head byte is read straight
// from the storage flops so it is valid whenever the FIFO is not empty.
module sync_byte_fifo
    import coinc_usb_pkg::*;
#(
    parameter int DEPTH = 16
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   push,
    input  logic [BYTE_W-1:0]      din,
    input  logic                   pop,
    output logic [BYTE_W-1:0]      head,
    output logic                   full,
    output logic                   empty,
    output logic [$clog2(DEPTH):0] count
);

    localparam int AW = $clog2(DEPTH);
    localparam logic [AW:0] FULL_COUNT = (AW+1)'(DEPTH);

    logic [BYTE_W-1:0] mem [DEPTH];
    logic [AW-1:0]     wr_ptr;
    logic [AW-1:0]     rd_ptr;
    logic              do_push;
    logic              do_pop;

    assign full    = (count == FULL_COUNT);
    assign empty   = (count == '0);
    assign do_push = push & ~full;
    assign do_pop  = pop & ~empty;
    assign head    = mem[rd_ptr];

    always_ff @(posedge clk) begin
        if (do_push) begin
            mem[wr_ptr] <= din;
        end
    end

    // Pointers wrap naturally because DEPTH is a power of two.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) begin
                wr_ptr <= wr_ptr + AW'(1);
            end
            if (do_pop) begin
                rd_ptr <= rd_ptr + AW'(1);
            end
            case ({do_push, do_pop})
                2'b10:   count <= count + (AW+1)'(1);
                2'b01:   count <= count - (AW+1)'(1);
                default: count <= count;
            endcase
        end
    end

endmodule

// File: rtl/usb_fifo_responder.sv
// Device side of the FT245-style byte link: answers the controller's RD/WR strobes
// from an RX FIFO fed by the host and into a TX FIFO drained by the host.
module usb_fifo_responder
    import coinc_usb_pkg::*;
#(
    parameter int RX_DEPTH   = 16,
    parameter int TX_DEPTH   = 256,
    parameter int RXF_PRE    = 2,
    parameter int TXE_MARGIN = 2
) (
    input  logic              CLK,
    input  logic              RSTN,
    input  logic              RD,
    input  logic              WR,
    input  logic [BYTE_W-1:0] USB_DIN,
    output logic [BYTE_W-1:0] USB_DOUT,
    output logic              USB_DOE,
    output logic              RXF,
    output logic              TXE,
    input  logic [BYTE_W-1:0] H_RX_DATA,
    input  logic              H_RX_VALID,
    output logic              H_RX_READY,
    output logic [BYTE_W-1:0] H_TX_DATA,
    output logic              H_TX_VALID,
    input  logic              H_TX_READY,
    output logic              OVF,
    output logic              UNF
);

    localparam int RX_AW = $clog2(RX_DEPTH);
    localparam int TX_AW = $clog2(TX_DEPTH);
    localparam int HCW   = (RXF_PRE > 1) ? $clog2(RXF_PRE) : 1;
    localparam logic [HCW-1:0]  HOLD_LOAD     = HCW'(RXF_PRE - 1);
    localparam logic [TX_AW:0]  TX_BUSY_LEVEL = (TX_AW+1)'(TX_DEPTH - TXE_MARGIN);

    logic              rd_s1, rd_s2, rd_s3;
    logic              wr_s1, wr_s2, wr_s3;
    logic [BYTE_W-1:0] din_s1, din_s2, din_s3;
    logic              rd_fall, rd_rise, wr_fall;
    logic              up_q;
    rd_state_e         state;
    logic [HCW-1:0]    hold_cnt;
    logic              drive_empty;

    logic [BYTE_W-1:0] rx_head;
    logic              rx_full, rx_empty, rx_push, rx_pop;
    logic [RX_AW:0]    rx_count;
    logic              tx_full, tx_empty, tx_push, tx_pop;
    logic [TX_AW:0]    tx_count;

    // Strobes arrive asynchronously; the bus byte travels with WR so the value
    // seen at the WR fall was sampled while the controller still drove it.
    always_ff @(posedge CLK or negedge RSTN) begin
        if (!RSTN) begin
            rd_s1  <= 1'b1;
            rd_s2  <= 1'b1;
            rd_s3  <= 1'b1;
            wr_s1  <= 1'b0;
            wr_s2  <= 1'b0;
            wr_s3  <= 1'b0;
            din_s1 <= '0;
            din_s2 <= '0;
            din_s3 <= '0;
            up_q   <= 1'b0;
        end else begin
            rd_s1  <= RD;
            rd_s2  <= rd_s1;
            rd_s3  <= rd_s2;
            wr_s1  <= WR;
            wr_s2  <= wr_s1;
            wr_s3  <= wr_s2;
            din_s1 <= USB_DIN;
            din_s2 <= din_s1;
            din_s3 <= din_s2;
            up_q   <= 1'b1;
        end
    end

    assign rd_fall = rd_s3 & ~rd_s2;
    assign rd_rise = ~rd_s3 & rd_s2;
    assign wr_fall = wr_s3 & ~wr_s2;

    assign H_RX_READY = up_q & ~rx_full;
    assign rx_push    = H_RX_VALID & H_RX_READY;
    assign rx_pop     = (state == RD_DRIVE) & rd_rise & ~drive_empty;

    assign H_TX_VALID = ~tx_empty;
    assign tx_pop     = H_TX_VALID & H_TX_READY;
    assign tx_push    = wr_fall & ~tx_full;
    assign TXE        = ~up_q | (tx_count > TX_BUSY_LEVEL);

    // A read that starts on an empty FIFO drives zero for the whole strobe and pops nothing.
    always_ff @(posedge CLK or negedge RSTN) begin
        if (!RSTN) begin
            state       <= RD_IDLE;
            USB_DOE     <= 1'b0;
            USB_DOUT    <= '0;
            RXF         <= 1'b1;
            UNF         <= 1'b0;
            hold_cnt    <= '0;
            drive_empty <= 1'b0;
        end else begin
            case (state)
                RD_IDLE: begin
                    if (rd_fall) begin
                        state       <= RD_DRIVE;
                        RXF         <= 1'b1;
                        USB_DOE     <= 1'b1;
                        drive_empty <= rx_empty;
                        USB_DOUT    <= rx_empty ? '0 : rx_head;
                        if (rx_empty) begin
                            UNF <= 1'b1;
                        end
                    end else begin
                        RXF <= (rx_count == '0);
                    end
                end
                RD_DRIVE: begin
                    USB_DOUT <= drive_empty ? '0 : rx_head;
                    if (rd_rise) begin
                        state    <= RD_HOLD;
                        USB_DOE  <= 1'b0;
                        hold_cnt <= HOLD_LOAD;
                    end
                end
                RD_HOLD: begin
                    if (hold_cnt == '0) begin
                        state <= RD_IDLE;
                    end else begin
                        hold_cnt <= hold_cnt - HCW'(1);
                    end
                end
                default: begin
                    state <= RD_IDLE;
                end
            endcase
        end
    end

    always_ff @(posedge CLK or negedge RSTN) begin
        if (!RSTN) begin
            OVF <= 1'b0;
        end else if (wr_fall && tx_full) begin
            OVF <= 1'b1;
        end
    end

    sync_byte_fifo #(.DEPTH(RX_DEPTH)) u_rx_fifo (
        .clk   (CLK),
        .rst_n (RSTN),
        .push  (rx_push),
        .din   (H_RX_DATA),
        .pop   (rx_pop),
        .head  (rx_head),
        .full  (rx_full),
        .empty (rx_empty),
        .count (rx_count)
    );

    sync_byte_fifo #(.DEPTH(TX_DEPTH)) u_tx_fifo (
        .clk   (CLK),
        .rst_n (RSTN),
        .push  (tx_push),
        .din   (din_s3),
        .pop   (tx_pop),
        .head  (H_TX_DATA),
        .full  (tx_full),
        .empty (tx_empty),
        .count (tx_count)
    );

endmodule

// File: tb/tb_usb_fifo_responder.sv
// Self-checking bench for usb_fifo_responder: byte queues model both FIFOs and the
// sticky flags, and each scenario task compares the bus/host outputs against them.
module tb_usb_fifo_responder;
    import coinc_usb_pkg::*;

    localparam int RX_DEPTH = 16;
    localparam int TX_DEPTH = 256;

    logic       CLK = 1'b0;
    logic       RSTN = 1'b1;
    logic       RD = 1'b1;
    logic       WR = 1'b0;
    logic [7:0] USB_DIN = 8'h00;
    logic [7:0] USB_DOUT;
    logic       USB_DOE;
    logic       RXF;
    logic       TXE;
    logic [7:0] H_RX_DATA = 8'h00;
    logic       H_RX_VALID = 1'b0;
    logic       H_RX_READY;
    logic [7:0] H_TX_DATA;
    logic       H_TX_VALID;
    logic       H_TX_READY = 1'b0;
    logic       OVF;
    logic       UNF;

    int checks = 0;
    int failures = 0;

    logic [7:0] rx_q[$];
    logic [7:0] tx_q[$];
    bit         ovf_m = 1'b0;
    bit         unf_m = 1'b0;

    logic [7:0] cmd_tab [12] = '{CMD_CLEAR, CMD_ADRCLR, CMD_WAVE, CMD_RDINIT, CMD_XFER, CMD_IDLE,
                                 CMD_NORMAL, CMD_LEN, CMD_THUP32, CMD_THDN32, CMD_THUP4, CMD_THDN4};

    always #4 CLK = ~CLK;

    usb_fifo_responder #(
        .RX_DEPTH(RX_DEPTH), .TX_DEPTH(TX_DEPTH), .RXF_PRE(2), .TXE_MARGIN(2)
    ) dut (
        .CLK(CLK), .RSTN(RSTN), .RD(RD), .WR(WR), .USB_DIN(USB_DIN),
        .USB_DOUT(USB_DOUT), .USB_DOE(USB_DOE), .RXF(RXF), .TXE(TXE),
        .H_RX_DATA(H_RX_DATA), .H_RX_VALID(H_RX_VALID), .H_RX_READY(H_RX_READY),
        .H_TX_DATA(H_TX_DATA), .H_TX_VALID(H_TX_VALID), .H_TX_READY(H_TX_READY),
        .OVF(OVF), .UNF(UNF)
    );

    task automatic tick(input int n);
        repeat (n) @(posedge CLK);
        #1;
    endtask

    task automatic host_push(input logic [7:0] b, input string tag);
        bit exp_ready;
        exp_ready = (rx_q.size() < RX_DEPTH);
        H_RX_DATA  = b;
        H_RX_VALID = 1'b1;
        checks++;
        if (H_RX_READY !== exp_ready) begin
            failures++;
            $display("[TB] FAIL %s h_rx_ready: got %b expected %b", tag, H_RX_READY, exp_ready);
        end
        if (exp_ready) rx_q.push_back(b);
        tick(1);
        H_RX_VALID = 1'b0;
    endtask

    // Controller read strobe, RD low 5 cycles; optionally a host push lands on the pop edge.
    task automatic rd_strobe(input string tag, input bit collide, input logic [7:0] cb);
        bit         emp;
        logic [7:0] exp;
        tick(2);
        emp = (rx_q.size() == 0);
        exp = emp ? 8'h00 : rx_q.pop_front();
        checks++;
        if (RXF !== emp) begin
            failures++;
            $display("[TB] FAIL %s rxf_before: got %b expected %b", tag, RXF, emp);
        end
        RD = 1'b0;
        tick(3);
        checks++;
        if (USB_DOE !== 1'b1 || USB_DOUT !== exp || RXF !== 1'b1) begin
            failures++;
            $display("[TB] FAIL %s drive: got doe=%b dout=%h rxf=%b expected doe=1 dout=%h rxf=1",
                     tag, USB_DOE, USB_DOUT, RXF, exp);
        end
        tick(2);
        RD = 1'b1;
        if (collide) begin
            tick(2);
            host_push(cb, {tag, "_collide"});
            tick(7);
        end else begin
            tick(10);
        end
        if (emp) unf_m = 1'b1;
        checks++;
        if (UNF !== unf_m || USB_DOE !== 1'b0) begin
            failures++;
            $display("[TB] FAIL %s after: got unf=%b doe=%b expected unf=%b doe=0", tag, UNF, USB_DOE, unf_m);
        end
        checks++;
        if (RXF !== (rx_q.size() == 0)) begin
            failures++;
            $display("[TB] FAIL %s rxf_after: got %b expected %b", tag, RXF, rx_q.size() == 0);
        end
    endtask

    task automatic ctrl_write(input logic [7:0] b, input int hi, input int lo);
        WR = 1'b1;
        USB_DIN = b;
        tick(hi);
        WR = 1'b0;
        USB_DIN = 8'($urandom);
        if (tx_q.size() < TX_DEPTH) tx_q.push_back(b);
        else ovf_m = 1'b1;
        tick(lo);
    endtask

    task automatic drain_tx(input string tag);
        logic [7:0] exp;
        H_TX_READY = 1'b1;
        while (tx_q.size() > 0) begin
            exp = tx_q.pop_front();
            checks++;
            if (H_TX_VALID !== 1'b1 || H_TX_DATA !== exp) begin
                failures++;
                $display("[TB] FAIL %s h_tx: got valid=%b data=%h expected valid=1 data=%h",
                         tag, H_TX_VALID, H_TX_DATA, exp);
            end
            tick(1);
        end
        H_TX_READY = 1'b0;
        checks++;
        if (H_TX_VALID !== 1'b0) begin
            failures++;
            $display("[TB] FAIL %s h_tx_empty: got valid=%b expected 0", tag, H_TX_VALID);
        end
    endtask

    task automatic test_reset();
        #2 RSTN = 1'b0;
        tick(2);
        checks++;
        if (USB_DOUT !== 8'h00 || USB_DOE !== 1'b0 || RXF !== 1'b1 || TXE !== 1'b1) begin
            failures++;
            $display("[TB] FAIL reset_bus: got dout=%h doe=%b rxf=%b txe=%b expected 00 0 1 1",
                     USB_DOUT, USB_DOE, RXF, TXE);
        end
        checks++;
        if (H_RX_READY !== 1'b0 || H_TX_VALID !== 1'b0 || OVF !== 1'b0 || UNF !== 1'b0) begin
            failures++;
            $display("[TB] FAIL reset_host: got rdy=%b vld=%b ovf=%b unf=%b expected 0 0 0 0",
                     H_RX_READY, H_TX_VALID, OVF, UNF);
        end
        RSTN = 1'b1;
        tick(1);
        checks++;
        if (TXE !== 1'b0 || H_RX_READY !== 1'b1) begin
            failures++;
            $display("[TB] FAIL reset_release: got txe=%b rdy=%b expected 0 1", TXE, H_RX_READY);
        end
    endtask

    task automatic test_rd_single();
        host_push(CMD_NORMAL, "rd_single_push");
        rd_strobe("rd_single", 1'b0, 8'h00);
    endtask

    task automatic test_ctrl_pair();
        ctrl_write(8'h34, 4, 7);
        ctrl_write(8'h12, 5, 4);
        checks++;
        if (OVF !== 1'b0) begin
            failures++;
            $display("[TB] FAIL pair_ovf: got %b expected 0", OVF);
        end
        drain_tx("pair");
    endtask

    task automatic test_tx_overflow();
        bit exp_txe;
        H_TX_READY = 1'b0;
        for (int n = 1; n <= TX_DEPTH + 1; n++) begin
            ctrl_write(8'($urandom), 4, 4);
            exp_txe = ((TX_DEPTH - tx_q.size()) < 2);
            if (n >= TX_DEPTH - 2) begin
                checks++;
                if (TXE !== exp_txe || OVF !== ovf_m) begin
                    failures++;
                    $display("[TB] FAIL ovf_write%0d: got txe=%b ovf=%b expected txe=%b ovf=%b",
                             n, TXE, OVF, exp_txe, ovf_m);
                end
            end
        end
        drain_tx("ovf_drain");
        checks++;
        if (TXE !== 1'b0 || OVF !== 1'b1) begin
            failures++;
            $display("[TB] FAIL ovf_sticky: got txe=%b ovf=%b expected 0 1", TXE, OVF);
        end
    endtask

    task automatic test_rd_empty();
        rd_strobe("rd_empty", 1'b0, 8'h00);
        host_push(CMD_THUP4, "rd_empty_push");
        rd_strobe("rd_empty_next", 1'b0, 8'h00);
    endtask

    task automatic test_random();
        int op;
        for (int i = 0; i < 80; i++) begin
            op = $urandom_range(0, 5);
            case (op)
                0, 1, 2: host_push(cmd_tab[$urandom_range(0, 11)], "rand_push");
                3: rd_strobe("rand_read", 1'b0, 8'h00);
                4: begin
                    ctrl_write(8'($urandom), $urandom_range(4, 6), $urandom_range(4, 6));
                    checks++;
                    if (OVF !== ovf_m) begin
                        failures++;
                        $display("[TB] FAIL rand_ovf: got %b expected %b", OVF, ovf_m);
                    end
                end
                default: drain_tx("rand_drain");
            endcase
        end
        drain_tx("rand_final");
    endtask

    task automatic test_reset_mid();
        host_push(CMD_XFER, "mid_push");
        ctrl_write(8'h5A, 4, 4);
        tick(2);
        RD = 1'b0;
        tick(3);
        checks++;
        if (USB_DOE !== 1'b1) begin
            failures++;
            $display("[TB] FAIL mid_drive: got doe=%b expected 1", USB_DOE);
        end
        RSTN = 1'b0;
        #1;
        checks++;
        if (USB_DOE !== 1'b0 || RXF !== 1'b1 || OVF !== 1'b0 || UNF !== 1'b0 || H_TX_VALID !== 1'b0) begin
            failures++;
            $display("[TB] FAIL mid_async: got doe=%b rxf=%b ovf=%b unf=%b vld=%b expected 0 1 0 0 0",
                     USB_DOE, RXF, OVF, UNF, H_TX_VALID);
        end
        rx_q.delete();
        tx_q.delete();
        ovf_m = 1'b0;
        unf_m = 1'b0;
        RD = 1'b1;
        tick(2);
        RSTN = 1'b1;
        tick(1);
        checks++;
        if (TXE !== 1'b0 || H_RX_READY !== 1'b1) begin
            failures++;
            $display("[TB] FAIL mid_release: got txe=%b rdy=%b expected 0 1", TXE, H_RX_READY);
        end
        tick(8);
        checks++;
        if (RXF !== 1'b1 || USB_DOE !== 1'b0 || H_TX_VALID !== 1'b0) begin
            failures++;
            $display("[TB] FAIL mid_flushed: got rxf=%b doe=%b vld=%b expected 1 0 0", RXF, USB_DOE, H_TX_VALID);
        end
    endtask

    task automatic test_push_pop_collide();
        host_push(CMD_THDN32, "collide_first");
        rd_strobe("collide", 1'b1, CMD_LEN);
        rd_strobe("collide_second", 1'b0, 8'h00);
    endtask

    initial begin
        test_reset();
        test_rd_single();
        test_ctrl_pair();
        test_tx_overflow();
        test_rd_empty();
        test_random();
        test_reset_mid();
        test_push_pop_collide();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
